mux_nto1_hs: RTL
================

// Module: mux_nto1_hs
// PURPOSE
//  Parametrised N:1 multiplexer with a registered output and valid/ready handshake on every channel.
//  Successor to the 2:1 combinational mux. Adds arbitrary width and channel count, a registered
//  one-deep output stage with backpressure, and a round-robin mode alongside fixed select.
//  Sits between several producers and one consumer in the datapath.
// PARAMETERS
//  WIDTH     8   data bits per channel
//  CHANNELS  4   number of input channels (>=2, need not be a power of 2)
//  SEL_W     localparam = $clog2(CHANNELS); width of sel and out_ch
// PORTS
//  clk        in   1               rising-edge clock
//  reset      in   1               synchronous, active-high reset
//  in_data    in   CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH]
//  in_valid   in   CHANNELS        per-channel data valid
//  in_ready   out  CHANNELS        per-channel accept (combinational)
//  sel        in   SEL_W           channel index used in fixed mode
//  rr_mode    in   1               0 = fixed select, 1 = round-robin
//  out_data   out  WIDTH           registered output data
//  out_ch     out  SEL_W           source channel of out_data
//  out_valid  out  1               output register holds data
//  out_ready  in   1               consumer accepts
//  xfer_count out  16              only with MUX_STATS_EN
// BEHAVIOUR
//  - Reset (sync, any time, including mid-transfer): out_valid=0, out_data=0, out_ch=0,
//    rr_ptr=0, xfer_count=0. Any data held in the output register is dropped.
//  - States: EMPTY (out_valid=0) and FULL (out_valid=1).
//    load_en = !out_valid | out_ready.
//    EMPTY->FULL on an input transfer. FULL->EMPTY on an output transfer with no input transfer.
//    FULL stays FULL when both transfers occur in the same cycle.
//  - Channel choice c:
//    fixed mode: c = sel.
//    rr mode: first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod CHANNELS.
//  - in_ready[i] = load_en & (i==c) & chosen_ok. All other bits are 0.
//    fixed mode: chosen_ok = (sel < CHANNELS), independent of valid.
//    rr mode: chosen_ok = |in_valid.
//  - Input transfer (in_valid[c] & in_ready[c]) at cycle t:
//    out_data = in_data[c], out_ch = c, out_valid=1 at t+1.
//    Latency 1 cycle. Throughput 1 word/cycle while out_ready=1.
//  - While out_valid & !out_ready: out_data and out_ch are held stable. Changes to sel or rr_mode
//    have no effect on the held word.
//  - rr_ptr updates only on an rr-mode input transfer: rr_ptr = (c==CHANNELS-1) ? 0 : c+1.
//    It is unchanged in fixed mode.
//  - Changing rr_mode takes effect on the same cycle's choice. It never alters the register contents.
//  - sel >= CHANNELS (non-power-of-2 CHANNELS): no channel is ready, nothing is loaded.
// CONFIGURATION
//  MUX_STATS_EN defined:
//    - xfer_count increments on each output transfer (out_valid & out_ready).
//    - It wraps 16'hFFFF -> 0 and is cleared by reset.
//  MUX_STATS_EN undefined: the xfer_count port and counter are absent. All other behaviour is identical.
// STRUCTURE
//  - Shared include mux_defs.vh holds MODE_FIXED=1'b0, MODE_RR=1'b1 and STATS_W=16.
//  - Sub-module rr_pick (combinational):
//    inputs: valid vector, ptr.
//    outputs: grant index, any.
//    It is parametrised by CHANNELS and instantiated once.
// TESTING
//  1 Reset: drive reset=1 for 2 cycles with in_valid=4'hF -> out_valid=0, out_data=0, in_ready=0 during reset.
//  2 Fixed mode, W=8, sel=2, in_data[2]=8'hA5, in_valid=4'b0100, out_ready=1
//    -> in_ready=4'b0100; next cycle out_data=A5, out_ch=2, out_valid=1.
//  3 Backpressure: out_ready=0 with the register FULL; change sel to 1 and data to 8'h3C
//    -> out_data stays A5, in_ready=0. Raise out_ready -> 3C appears the next cycle.
//  4 RR mode, in_valid=4'hF, out_ready=1 for 5 cycles -> out_ch sequence 0,1,2,3,0 (wrap).
//    Repeat with in_valid=4'b1010 -> 1,3,1.
//  5 CHANNELS=3, fixed mode, sel=3 -> in_ready=0 and out_valid stays 0. Assert reset while FULL -> out_valid=0 next cycle.
//  6 MUX_STATS_EN: 10 output transfers -> xfer_count=10. Reset -> 0.
//    Preload 16'hFFFF, then 1 transfer -> 0.

Source files
------------

// File: rtl/mux_nto1_hs_pkg.sv
// ----------------------------------------------------------------------------
// mux_nto1_hs_pkg
// Shared definitions for the N:1 handshake multiplexer: mode encodings,
// statistics counter width and the output-stage state type.
// Optional feature macro: MUX_STATS_EN (adds the xfer_count port/counter).
// ----------------------------------------------------------------------------
package mux_nto1_hs_pkg;

    // Encodings of the rr_mode input
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Width of the output-transfer statistics counter
    localparam int unsigned STATS_W = 16;

    // One-deep output register occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } muxState_t;

endpackage

// File: rtl/mux_nto1_hs_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first set bit of `valid`,
// searching from `ptr` upwards and wrapping modulo CHANNELS.
// Ports:
//   valid  in   CHANNELS   request vector
//   ptr    in   SEL_W      search start index (always < CHANNELS)
//   grant  out  SEL_W      chosen index (0 when nothing is requested)
//   any    out  1          at least one request present
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter  int unsigned CHANNELS = 4,
    localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] valid,
    input  logic [SEL_W-1:0]    ptr,
    output logic [SEL_W-1:0]    grant,
    output logic                any
);

    // One extra bit so ptr + offset never overflows before the wrap
    localparam int unsigned SUM_W = SEL_W + 1;

    logic [2*CHANNELS-1:0] doubled;
    logic [CHANNELS-1:0]   rotated;
    logic [SUM_W-1:0]      sum;

    // Rotate so that bit 0 of `rotated` corresponds to channel `ptr`
    assign doubled = {valid, valid};
    assign rotated = CHANNELS'(doubled >> ptr);

    // Lowest set offset wins; descending scan lets the lowest overwrite last
    always_comb begin
        any = 1'b0;
        sum = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                sum = SUM_W'(ptr) + SUM_W'(k);
                any = 1'b1;
            end
        end
        grant = (sum >= SUM_W'(CHANNELS)) ? SEL_W'(sum - SUM_W'(CHANNELS))
                                          : SEL_W'(sum);
    end

endmodule

// File: rtl/mux_nto1_hs.sv
// ----------------------------------------------------------------------------
// mux_nto1_hs
// Parametrised N:1 multiplexer with a one-deep registered output stage and
// valid/ready handshake on every channel. Fixed-select or round-robin choice.
// Optional feature macro: MUX_STATS_EN (output-transfer counter xfer_count).
// Ports:
//   clk         in   1               rising-edge clock
//   reset       in   1               synchronous active-high reset
//   in_data     in   CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid    in   CHANNELS        per-channel valid
//   in_ready    out  CHANNELS        per-channel accept (combinational)
//   sel         in   SEL_W           channel index in fixed mode
//   rr_mode     in   1               0 = fixed, 1 = round-robin
//   out_data    out  WIDTH           registered data
//   out_ch      out  SEL_W           source channel of out_data
//   out_valid   out  1               output register holds data
//   out_ready   in   1               consumer accepts
//   xfer_count  out  16              output transfers (MUX_STATS_EN only)
// ----------------------------------------------------------------------------
module mux_nto1_hs
    import mux_nto1_hs_pkg::*;
#(
    parameter  int unsigned WIDTH    = 8,
    parameter  int unsigned CHANNELS = 4,
    localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      rr_mode,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef MUX_STATS_EN
    ,
    output logic [STATS_W-1:0]        xfer_count
`endif
);

    muxState_t        state;
    logic [SEL_W-1:0] rrPtr;
    logic [SEL_W-1:0] rrGrant;
    logic             rrAny;
    logic [SEL_W-1:0] chosen;
    logic             chosenOk;
    logic             loadEn;
    logic             xferIn;
    logic             xferOut;
    logic [WIDTH-1:0] chosenData;

    // Round-robin candidate from the current pointer
    rr_pick #(
        .CHANNELS (CHANNELS)
    ) u_rrPick (
        .valid (in_valid),
        .ptr   (rrPtr),
        .grant (rrGrant),
        .any   (rrAny)
    );

    assign out_valid = (state == ST_FULL);
    assign loadEn    = !out_valid || out_ready;
    assign xferOut   = out_valid && out_ready;

    // Channel choice; fixed mode with an out-of-range sel selects nothing
    always_comb begin
        chosen   = sel;
        chosenOk = ({1'b0, sel} < (SEL_W + 1)'(CHANNELS));
        if (rr_mode == MODE_RR) begin
            chosen   = rrGrant;
            chosenOk = rrAny;
        end
    end

    // One-hot ready on the chosen channel; silenced while reset is asserted
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = !reset && loadEn && chosenOk && (chosen == SEL_W'(i));
        end
    end

    assign xferIn = |(in_valid & in_ready);

    // Data of the chosen channel (unused when nothing is ready)
    always_comb begin
        chosenData = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (chosen == SEL_W'(i)) begin
                chosenData = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage occupancy, payload and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_EMPTY;
            out_data <= '0;
            out_ch   <= '0;
            rrPtr    <= '0;
        end else begin
            case (state)
                ST_EMPTY: if (xferIn)              state <= ST_FULL;
                ST_FULL:  if (xferOut && !xferIn)  state <= ST_EMPTY;
                default:                           state <= ST_EMPTY;
            endcase
            if (xferIn) begin
                out_data <= chosenData;
                out_ch   <= chosen;
                if (rr_mode == MODE_RR) begin
                    rrPtr <= (chosen == SEL_W'(CHANNELS - 1)) ? '0
                                                              : chosen + SEL_W'(1);
                end
            end
        end
    end

`ifdef MUX_STATS_EN
    // Free-running output-transfer counter, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_count <= '0;
        end else if (xferOut) begin
            xfer_count <= xfer_count + STATS_W'(1);
        end
    end
`endif

endmodule
